// File: rtl/x25519_pkg.sv
// Shared field constant, step opcodes, FSM states and the fixed
// dbl-2008-bbjlp step program for the sequential doubling engine.
package x25519_pkg;

    localparam logic [254:0] P25519 = {255{1'b1}} - 255'd18;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_NEG,
        OP_MUL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_MUL,
        ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        R_X, R_Y, R_Z, R_T, R_B, R_C,
        R_D, R_H, R_E, R_F, R_J
    } reg_e;

    localparam int NREG  = 11;
    localparam int NSTEP = 15;

    typedef struct packed {
        op_e  op;
        reg_e dst;
        reg_e srca;
        reg_e srcb;
    } step_t;

    // X3, Y3, Z3 land in the X, Y, Z slots once those inputs are dead.
    localparam step_t SCHED [NSTEP] = '{
        '{OP_ADD, R_T, R_X, R_Y},
        '{OP_MUL, R_B, R_T, R_T},
        '{OP_MUL, R_C, R_X, R_X},
        '{OP_MUL, R_D, R_Y, R_Y},
        '{OP_MUL, R_H, R_Z, R_Z},
        '{OP_NEG, R_E, R_C, R_C},
        '{OP_ADD, R_F, R_E, R_D},
        '{OP_ADD, R_H, R_H, R_H},
        '{OP_SUB, R_J, R_F, R_H},
        '{OP_SUB, R_T, R_B, R_C},
        '{OP_SUB, R_T, R_T, R_D},
        '{OP_MUL, R_X, R_T, R_J},
        '{OP_SUB, R_T, R_E, R_D},
        '{OP_MUL, R_Y, R_F, R_T},
        '{OP_MUL, R_Z, R_F, R_J}
    };

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier, WIDTH+2 cycles
// from start to the single-cycle done pulse. Operands must be < P.
module mod_mul_serial #(
    parameter int unsigned      WIDTH = 255,
    parameter logic [WIDTH-1:0] P     = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH:0]   dbl, dbl_r, sum;

    always_comb begin
        dbl   = {acc_q, 1'b0};
        dbl_r = (dbl >= {1'b0, P}) ? dbl - {1'b0, P} : dbl;
        sum   = {1'b0, dbl_r[WIDTH-1:0]} + {1'b0, a_q};
        acc_d = dbl_r[WIDTH-1:0];
        if (b_q[WIDTH-1]) begin
            acc_d = (sum >= {1'b0, P}) ? WIDTH'(sum - {1'b0, P})
                                       : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            acc_q <= acc_d;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/ed_point_double_seq.sv
// Sequential twisted-Edwards projective point doubling (dbl-2008-bbjlp)
// using one shared serial multiplier and one modular add/sub unit.
module ed_point_double_seq
    import x25519_pkg::*;
#(
    parameter int unsigned      WIDTH  = 255,
    parameter logic [WIDTH-1:0] P      = WIDTH'(P25519),
    parameter int unsigned      A_NEG1 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] z1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] z2
);

    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d, step_nx;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] x2_q, y2_q, z2_q;
    step_t            cur;
    logic [WIDTH-1:0] opa, opb, as_res, mul_p, wdata;
    logic [WIDTH:0]   sum, dif;
    logic             mul_start, mul_busy, mul_done;
    logic             ld, we, adv, fin;

    assign cur     = SCHED[step_q];
    assign opa     = rf_q[cur.srca];
    assign opb     = rf_q[cur.srcb];
    assign step_nx = step_q + 4'd1;

    always_comb begin
        sum    = {1'b0, opa} + {1'b0, opb};
        dif    = {1'b0, opa} - {1'b0, opb};
        as_res = opa;
        unique case (cur.op)
            OP_ADD: as_res = (sum >= {1'b0, P}) ? WIDTH'(sum - {1'b0, P})
                                                : sum[WIDTH-1:0];
            OP_SUB: as_res = dif[WIDTH] ? WIDTH'(dif + {1'b0, P})
                                        : dif[WIDTH-1:0];
            // a = -1 turns E = a*C into P-C, keeping 0 at 0.
            OP_NEG: as_res = (A_NEG1 != 0 && opa != '0) ? P - opa : opa;
            OP_MUL: as_res = opa;
        endcase
    end

    mod_mul_serial #(
        .WIDTH (WIDTH),
        .P     (P)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        wdata     = as_res;
        mul_start = 1'b0;
        ld        = 1'b0;
        we        = 1'b0;
        adv       = 1'b0;
        fin       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ld      = 1'b1;
                    step_d  = '0;
                    state_d = (SCHED[0].op == OP_MUL) ? ST_MUL : ST_ADD;
                end
            end
            ST_ADD: begin
                we  = 1'b1;
                adv = 1'b1;
            end
            ST_MUL: begin
                mul_start = !mul_busy && !mul_done;
                if (mul_done) begin
                    we    = 1'b1;
                    wdata = mul_p;
                    adv   = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
        if (adv) begin
            if (step_q == 4'(NSTEP - 1)) begin
                fin     = 1'b1;
                state_d = ST_DONE;
            end else begin
                step_d  = step_nx;
                state_d = (SCHED[step_nx].op == OP_MUL) ? ST_MUL : ST_ADD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            z2_q    <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (ld) begin
                rf_q[R_X] <= x1;
                rf_q[R_Y] <= y1;
                rf_q[R_Z] <= z1;
            end
            if (we) rf_q[cur.dst] <= wdata;
            // Last step writes Z3; X3 and Y3 already sit in X and Y.
            if (fin) begin
                x2_q <= rf_q[R_X];
                y2_q <= rf_q[R_Y];
                z2_q <= wdata;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign x2        = x2_q;
    assign y2        = y2_q;
    assign z2        = z2_q;

endmodule
